// File: rtl/mandlebrot_scheduler.sv
// Iteration scheduler for the mandlebrot core: admits pixels into free ring slots,
// recirculates returning z values and retires finished pixels to a one-entry output register.
module mandlebrot_scheduler #(
  parameter int WIDTH    = 8,
  parameter int CORE_LAT = 2*WIDTH+3,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int TAG_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_re_c,
  input  logic [WIDTH-1:0]  in_im_c,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  core_re,
  output logic [WIDTH-1:0]  core_im,
  output logic [WIDTH-1:0]  core_re_c,
  output logic [WIDTH-1:0]  core_im_c,
  output logic              core_valid,
  input  logic [WIDTH-1:0]  core_re_o,
  input  logic [WIDTH-1:0]  core_im_o,
  input  logic              core_escaped,
  input  logic              core_valid_o,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_inset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sync_err
);

  localparam int L     = CORE_LAT + 1;
  localparam int CNT_W = $clog2(L + 1);

  // inset is kept with the slot so a parked pixel still knows whether it escaped
  typedef struct packed {
    logic              occ;
    logic              done;
    logic              inset;
    logic [WIDTH-1:0]  re_c;
    logic [WIDTH-1:0]  im_c;
    logic [TAG_W-1:0]  tag;
    logic [ITER_W-1:0] iter;
  } slot_t;

  slot_t              issue_q, issue_d;
  slot_t              side_q [CORE_LAT];
  slot_t              tail;
  logic [WIDTH-1:0]   z_re_d, z_im_d;
  logic [ITER_W-1:0]  n_iter, fin_iter;
  logic               hit_limit, finished, out_free, retire, slot_free, fin_inset;
  logic [CNT_W-1:0]   mask_cnt;

  assign tail       = side_q[CORE_LAT-1];
  assign core_valid = issue_q.occ;
  assign core_re_c  = issue_q.re_c;
  assign core_im_c  = issue_q.im_c;

  assign n_iter    = tail.iter + 1'b1;
  assign hit_limit = (n_iter == ITER_W'(MAX_ITER));
  assign finished  = tail.occ && (tail.done || core_escaped || hit_limit);
  assign out_free  = !out_valid || out_ready;
  assign retire    = finished && out_free;
  assign slot_free = !tail.occ || retire;
  assign fin_iter  = tail.done ? tail.iter : n_iter;
  assign fin_inset = tail.done ? tail.inset : (hit_limit && !core_escaped);
  assign in_ready  = !rst && slot_free;

  // returning slots always win; new pixels only fill a slot that is free this cycle
  always_comb begin
    issue_d = '0;
    z_re_d  = '0;
    z_im_d  = '0;
    if (tail.occ && !retire) begin
      issue_d       = tail;
      issue_d.done  = finished;
      issue_d.iter  = fin_iter;
      issue_d.inset = fin_inset;
      z_re_d        = core_re_o;
      z_im_d        = core_im_o;
    end else if (in_valid && in_ready) begin
      issue_d.occ  = 1'b1;
      issue_d.re_c = in_re_c;
      issue_d.im_c = in_im_c;
      issue_d.tag  = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q   <= '0;
      core_re   <= '0;
      core_im   <= '0;
      for (int i = 0; i < CORE_LAT; i++) side_q[i] <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_iter  <= '0;
      out_inset <= 1'b0;
      sync_err  <= 1'b0;
      mask_cnt  <= CNT_W'(L);
    end else begin
      issue_q   <= issue_d;
      core_re   <= z_re_d;
      core_im   <= z_im_d;
      side_q[0] <= issue_q;
      for (int i = 1; i < CORE_LAT; i++) side_q[i] <= side_q[i-1];

      if (retire) begin
        out_valid <= 1'b1;
        out_tag   <= tail.tag;
        out_iter  <= fin_iter;
        out_inset <= fin_inset;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // the core pipeline is not reset, so stale valids are ignored for one ring lap
      if (mask_cnt != '0) mask_cnt <= mask_cnt - 1'b1;
      else if (core_valid_o != tail.occ) sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mandlebrot_scheduler.sv
// Bench for mandlebrot_scheduler: stub core with scripted escape laps, tag scoreboard
// with expected iteration/timing, slot-occupancy model for in_ready, sync_err tracking.
module tb_mandlebrot_scheduler;
  localparam int WIDTH = 8, CORE_LAT = 19, L = 20, ITER_W = 8, MAX_ITER = 255, TAG_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIDTH-1:0]  in_re_c = '0, in_im_c = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0]  core_re, core_im, core_re_c, core_im_c, core_re_o, core_im_o;
  logic              core_valid, core_escaped, core_valid_o;
  logic [TAG_W-1:0]  out_tag;
  logic [ITER_W-1:0] out_iter;
  logic              out_inset, out_valid, sync_err;
  logic              out_ready = 1'b1;
  logic              drop_valid = 1'b0;

  always #5 clk = ~clk;

  mandlebrot_scheduler #(.WIDTH(WIDTH), .CORE_LAT(CORE_LAT), .ITER_W(ITER_W),
                         .MAX_ITER(MAX_ITER), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_re_c(in_re_c), .in_im_c(in_im_c), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .core_re(core_re), .core_im(core_im), .core_re_c(core_re_c), .core_im_c(core_im_c),
    .core_valid(core_valid),
    .core_re_o(core_re_o), .core_im_o(core_im_o), .core_escaped(core_escaped),
    .core_valid_o(core_valid_o),
    .out_tag(out_tag), .out_iter(out_iter), .out_inset(out_inset),
    .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
  );

  // stub core: re counts laps (z0=0, +1 per pass); re_c scripts the escape lap, 0 = never
  logic [WIDTH-1:0]    p_re [CORE_LAT];
  logic [WIDTH-1:0]    p_im [CORE_LAT];
  logic [CORE_LAT-1:0] p_v = '0, p_e = '0;

  always @(posedge clk) begin
    p_re[0] <= core_re + 8'd1;
    p_im[0] <= core_im ^ core_im_c;
    p_v     <= {p_v[CORE_LAT-2:0], core_valid};
    p_e     <= {p_e[CORE_LAT-2:0], (core_re_c != 8'd0) && (core_re + 8'd1 == core_re_c)};
    for (int i = 1; i < CORE_LAT; i++) begin
      p_re[i] <= p_re[i-1];
      p_im[i] <= p_im[i-1];
    end
  end

  assign core_re_o    = p_re[CORE_LAT-1];
  assign core_im_o    = p_im[CORE_LAT-1];
  assign core_escaped = p_e[CORE_LAT-1];
  assign core_valid_o = p_v[CORE_LAT-1] && !drop_valid;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int iter; bit inset; int cyc; } exp_t;
  exp_t sb [int];
  exp_t cur;
  int   busy_until [L];
  bit   ready_chk = 1'b1, tim_chk = 1'b1, exp_sync = 1'b0, held_v = 1'b0;
  logic [TAG_W-1:0]  h_tag;
  logic [ITER_W-1:0] h_iter;
  logic              h_inset;
  int   n_outv = 0, lap;

  // reference model, evaluated mid-cycle when all inputs for the coming edge are settled
  always @(negedge clk) begin
    if (!rst) begin
      chk("sync_err", sync_err, exp_sync);
      if (drop_valid) exp_sync = 1'b1;
      if (ready_chk) chk("in_ready", in_ready, busy_until[cyc % L] <= cyc);
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_tag", out_tag, h_tag);
        chk("hold_iter", out_iter, h_iter);
        chk("hold_inset", out_inset, h_inset);
      end
      if (out_valid) n_outv++;
      if (out_valid && out_ready) begin
        chk("out_tag_known", sb.exists(int'(out_tag)), 1);
        if (sb.exists(int'(out_tag))) begin
          cur = sb[int'(out_tag)];
          chk("out_iter", out_iter, cur.iter);
          chk("out_inset", out_inset, cur.inset);
          if (tim_chk) chk("out_cycle", cyc, cur.cyc);
          sb.delete(int'(out_tag));
        end
      end
      held_v  = out_valid && !out_ready;
      h_tag   = out_tag;
      h_iter  = out_iter;
      h_inset = out_inset;
      if (in_valid && in_ready) begin
        lap = (in_re_c == 8'd0) ? MAX_ITER : int'(in_re_c);
        sb[int'(in_tag)] = '{lap, in_re_c == 8'd0, cyc + lap*L + 1};
        busy_until[cyc % L] = cyc + lap*L;
      end
    end else begin
      sb.delete();
      foreach (busy_until[p]) busy_until[p] = 0;
      exp_sync = 1'b0;
      held_v   = 1'b0;
    end
  end

  bit rnd_ready = 1'b0;
  logic [TAG_W-1:0] next_tag = 16'h0001;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] script, output int t_acc);
    bit ok;
    int k;
    ok = 1'b0;
    k = 0;
    t_acc = -1;
    in_valid = 1'b1;
    in_re_c  = script;
    in_im_c  = 8'($urandom);
    in_tag   = next_tag;
    while (!ok && k < 400) begin
      @(negedge clk);
      ok = in_ready;
      t_acc = cyc;
      step();
      k++;
    end
    in_valid = 1'b0;
    next_tag = next_tag + 1'b1;
    chk("accepted", ok, 1);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      step();
      k++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  int t, n0;
  int acc [25];

  initial begin
    // reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_sync_err", sync_err, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_tag", out_tag, 0);
    chk("post_rst_out_iter", out_iter, 0);
    chk("post_rst_out_inset", out_inset, 0);
    step();

    // single pixel escaping on lap 3, then one that never escapes
    send(8'd3, t);
    drain(200);
    send(8'd0, t);
    drain(6000);

    // back-to-back burst of 25: first pixel holds its slot for two laps
    for (int i = 0; i < 25; i++)
      send((i == 0) ? 8'd2 : 8'($urandom_range(1, 3)), acc[i]);
    chk("b2b_first20", acc[19] - acc[0], 19);
    chk("b2b_stall", acc[20] - acc[19] > 1, 1);
    drain(400);

    // random traffic, output always ready: exact timing and in_ready checked
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) send(8'($urandom_range(1, 6)), t);
      else step();
    end
    drain(400);

    // random traffic with random backpressure
    ready_chk = 1'b0;
    tim_chk   = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) send(8'($urandom_range(1, 5)), t);
      else step();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain(1000);

    // long stall with three lap-1 escapes
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'd1, t);
    repeat (100) step();
    out_ready = 1'b1;
    drain(200);

    // reset with pixels in flight
    for (int i = 0; i < 10; i++) send(8'd8, t);
    repeat (30) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready_chk = 1'b1;
    tim_chk   = 1'b1;
    n0 = n_outv;
    repeat (300) step();
    chk("post_rst_outv", n_outv - n0, 0);
    chk("post_rst_sync", sync_err, 0);

    // dropped core_valid_o bit 40 cycles after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) send(8'd10, t);
    repeat (20) step();
    drop_valid = 1'b1;
    step();
    drop_valid = 1'b0;
    repeat (50) step();
    @(negedge clk);
    chk("sync_err_sticky", sync_err, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("sync_err_cleared", sync_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
